// File: rtl/fetch_pkg.sv
// Shared widths, reset defaults and the queue entry layout for the fetch stage.
package fetch_pkg;

  localparam int INSTR_W        = 32;
  localparam int DEFAULT_ADDR_W = 32;

  localparam logic [31:0]        DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h3400_0000;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]        instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush beats push, head is read combinationally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two and single-entry builds in range.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: sequential PC generation, 1-cycle ROM reads, a
// prefetch queue with credit-based issue, and redirect flush/squash.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W    = 32,
  parameter int                  DEPTH     = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [INSTR_W-1:0]  NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [ADDR_W-1:0]    out_pc,
  output logic [ADDR_W-1:0]    out_pc_seq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              squash;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic [CNT_W:0]    credit_limit;
  logic              issue;
  logic              do_pop;
  logic              resp_push;
  entry_t            push_entry;
  entry_t            head_entry;

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (head_entry)
  );

  // An inflight read holds a slot; a pop this cycle hands its slot straight back.
  assign credit_used  = {1'b0, count} + (CNT_W+1)'(inflight);
  assign credit_limit = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(do_pop);
  assign issue        = reset && !redirect_valid && (credit_used < credit_limit);

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;
  assign resp_push  = inflight && !squash;
  assign push_entry = '{pc: inflight_pc, instr: imem_data};

  assign out_valid  = (count != '0);
  assign do_pop     = out_valid && out_ready;
  assign out_instr  = out_valid ? head_entry.instr : NOP_INSTR;
  assign out_pc     = out_valid ? head_entry.pc : '0;
  assign out_pc_seq = out_valid ? head_entry.pc + ADDR_W'(4) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      squash      <= 1'b0;
    end else begin
      squash <= redirect_valid;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          fetch_pc    <= fetch_pc + ADDR_W'(4);
          inflight_pc <= fetch_pc;
        end
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-slot fetch stage.
- Generates sequential PCs and issues requests to an external synchronous instruction ROM with 1-cycle read latency.
- Buffers returned {pc, instr} pairs in a DEPTH-entry prefetch queue.
- Hands them to decode over a valid/ready handshake, so decode stalls no longer freeze the PC path.
- Jump/branch redirects flush the queue and squash the in-flight ROM read.

Parameters:
- ADDR_W, 32, PC and ROM address width in bits.
- DEPTH, 4, prefetch queue entries. Power of two, at least 1.
- RESET_PC, 32'h00400000, first fetch address after reset.
- NOP_INSTR, 32'h34000000, instruction presented when the queue is empty (ori $zero,$zero,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- imem_req  out  1  ROM read strobe for this cycle.
- imem_addr  out  ADDR_W  ROM read address, valid when imem_req=1.
- imem_data  in  32  ROM read data, valid the cycle after imem_req.
- redirect_valid  in  1  jump/branch taken.
- redirect_pc  in  ADDR_W  jump/branch target.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction; NOP_INSTR when out_valid=0.
- out_pc  out  ADDR_W  head PC; 0 when out_valid=0.
- out_pc_seq  out  ADDR_W  out_pc+4, for the link/branch base.

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, queue count=0, inflight=0, imem_req=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0.
- Issue rule: imem_req=1 when count+inflight<DEPTH and redirect_valid=0.
  - imem_addr=fetch_pc.
  - fetch_pc<=fetch_pc+4, wrapping modulo 2^ADDR_W.
  - inflight<=1.
- Response: the cycle after an issue, imem_data and the issued PC are written to the queue tail, unless squashed. inflight<=0 unless a new issue occurs in the same cycle.
- Credit accounting: inflight responses are counted against capacity, so a write never overflows. A full queue simply stops issuing.
- Dequeue: out_valid=1 and out_ready=1 pops the head. The head is read combinationally from storage.
- Output values: out_valid=(count!=0). out_pc_seq=out_pc+4 when valid, otherwise 0.
- Simultaneous write and pop: both take effect and count is unchanged. Valid when full, because a pop frees credit for the next cycle's issue.
- Redirect (redirect_valid=1), highest priority:
  - count<=0, pointers reset.
  - inflight response discarded (squash flag set for exactly one cycle).
  - fetch_pc<=redirect_pc with bits [1:0] forced to 0.
  - No issue this cycle; the target is issued the next cycle.
  - A handshake on the same cycle still completes, since the consumer has already sampled the head.
- Redirect while empty or with nothing inflight: same behaviour; the squash flag is harmless.
- Back-to-back redirects: the last one wins, and no request is issued until redirect_valid=0.
- Latency:
  - Reset release to first out_valid: 2 cycles (issue at cycle 0, data at cycle 1, head visible at cycle 2).
  - Redirect to first target instruction valid: 3 cycles.
- Throughput: with DEPTH>=2 and out_ready=1, one instruction per cycle is sustained. DEPTH=1 gives one per 2 cycles.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Reset asserted mid-operation clears all state immediately. An imem_data return after reset release is ignored because inflight=0.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR and RESET_PC defaults.
  - INSTR_W=32.
  - A fetch_entry type {pc[ADDR_W], instr[32]}.
- Sub-module fetch_fifo: synchronous FIFO parametrised on width and depth, with push, pop and flush; count and data outputs; flush has priority over push.
- fetch_queue itself holds the PC register, issue/credit logic, squash flag and output muxing.

Test Plan:
1. Reset release, out_ready=1, ROM holding addr*2 → imem_addr 0x00400000, 0x00400004, ... each cycle; out_valid rises at cycle 2 with out_pc=0x00400000 and out_pc_seq=0x00400004; one instruction per cycle after that.
2. Backpressure: hold out_ready=0 for 10 cycles → exactly DEPTH(4) issues occur, imem_req stays 0 after the 4th, and no entry is lost or duplicated on release.
3. Redirect with a full queue and a read inflight, redirect_pc=0x00400103 → next cycle out_valid=0 and imem_addr=0x00400100 (low bits cleared); the squashed response never appears; first valid out_pc=0x00400100 three cycles after the redirect.
4. Redirect in the same cycle as a pop → the popped entry is consumed once, and no stale entry remains afterwards.
5. DEPTH=1 build, out_ready=1 → out_valid alternates, giving one instruction per 2 cycles with PCs strictly sequential.
6. Assert reset for 1 cycle mid-stream with inflight=1 → all outputs return to reset values at once, and fetch restarts at 0x00400000 with no stale data.
